// File: rtl/aec_pkg.sv
// Shared constants and state encoding for the expression-calculator arbiter.
package aec_pkg;

  localparam logic [6:0] ASC_EQ    = 7'h3D;
  localparam logic [6:0] ASC_PLUS  = 7'h2B;
  localparam logic [6:0] ASC_MINUS = 7'h2D;
  localparam logic [6:0] ASC_MUL   = 7'h2A;
  localparam logic [6:0] ASC_LP    = 7'h28;
  localparam logic [6:0] ASC_RP    = 7'h29;

  localparam int DEFAULT_MAXLEN = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    BURST    = 3'd2,
    WAIT_RES = 3'd3,
    RESP     = 3'd4
  } aec_state_e;

endpackage

// File: rtl/aec_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module aec_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            any
);

  // Scan from the farthest position down so the nearest request wins last.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant = IW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aec_arbiter.sv
// Round-robin front-end sharing one calculator engine among NREQ requesters.
// Optional engine watchdog: define AEC_ARB_WDOG_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for any request; picks next requester round-robin
// LOAD     | accepting the granted requester's characters through '='
// BURST    | streaming the buffer into the engine, one char per cycle
// WAIT_RES | waiting for the engine result strobe (or watchdog expiry)
// RESP     | one-cycle response pulse to the owning requester
module aec_arbiter
  import aec_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXLEN  = DEFAULT_MAXLEN,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [6:0]        rsp_result,
  output logic              rsp_err,
  output logic [6:0]        eng_ascii,
  output logic              eng_ready,
  output logic              eng_rst,
  input  logic              eng_valid,
  input  logic [6:0]        eng_result
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(MAXLEN);
  localparam int LW = $clog2(MAXLEN + 1);

  aec_state_e      state_q, state_d;
  logic [IW-1:0]   grant_q, rr_ptr_q, pick_idx;
  logic            pick_any;
  logic [LW-1:0]   wr_idx_q, len_q;
  logic [AW-1:0]   rd_idx_q;
  logic            ovf_q;
  logic [6:0]      buf_q [MAXLEN];
  logic [6:0]      res_q;
  logic            err_q;
  logic            rst_hold_q;
  logic            wd_hit, wd_expire;

  logic [6:0]      cur_char;
  logic            acc, acc_eq, at_full, burst_last;

  aec_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign cur_char   = req_char[int'(grant_q)*7 +: 7];
  assign acc        = (state_q == LOAD) && req_valid[grant_q];
  assign acc_eq     = acc && (cur_char == ASC_EQ);
  assign at_full    = (wr_idx_q == LW'(MAXLEN));
  assign burst_last = (LW'(rd_idx_q) == (len_q - 1'b1));

`ifdef AEC_ARB_WDOG_EN
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt_q;

  // Watchdog down-counter: preloaded during the burst, counts down in WAIT_RES.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == BURST) begin
      wd_cnt_q <= WD_LOAD;
    end else if ((state_q == WAIT_RES) && (wd_cnt_q != 8'd0)) begin
      wd_cnt_q <= wd_cnt_q - 8'd1;
    end
  end

  assign wd_hit = (wd_cnt_q == 8'd0);
`else
  assign wd_hit = 1'b0;
`endif

  // Next-state decode; a result strobe on the final watchdog cycle still wins.
  always_comb begin
    state_d   = state_q;
    wd_expire = 1'b0;
    case (state_q)
      IDLE:     if (pick_any) state_d = LOAD;
      LOAD:     if (acc_eq) state_d = (ovf_q || at_full) ? RESP : BURST;
      BURST:    if (burst_last) state_d = WAIT_RES;
      WAIT_RES: begin
        if (eng_valid) begin
          state_d = RESP;
        end else if (wd_hit) begin
          state_d   = RESP;
          wd_expire = 1'b1;
        end
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_err    = 1'b0;
    eng_ready  = 1'b0;
    eng_ascii  = '0;
    if (state_q == LOAD) req_ready[grant_q] = 1'b1;
    if (state_q == RESP) begin
      rsp_valid[grant_q] = 1'b1;
      rsp_result         = res_q;
      rsp_err            = err_q;
    end
    if (state_q == BURST) begin
      eng_ready = 1'b1;
      eng_ascii = buf_q[rd_idx_q];
    end
  end

  // State register and per-job bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_idx;
            rr_ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            wr_idx_q <= '0;
            ovf_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (acc) begin
            if (!at_full) wr_idx_q <= wr_idx_q + 1'b1;
            else          ovf_q    <= 1'b1;
          end
          if (acc_eq) begin
            rd_idx_q <= '0;
            len_q    <= wr_idx_q + 1'b1;
            if (ovf_q || at_full) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        BURST: rd_idx_q <= rd_idx_q + 1'b1;
        WAIT_RES: begin
          if (eng_valid) begin
            res_q <= eng_result;
            err_q <= 1'b0;
          end else if (wd_expire) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Character buffer; contents are don't-care until written in LOAD.
  always_ff @(posedge clk) begin
    if (acc && !at_full) buf_q[wr_idx_q[AW-1:0]] <= cur_char;
  end

  // Engine reset: held through reset, stretched one cycle past release, plus watchdog pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rst_hold_q <= 1'b1;
      eng_rst    <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      eng_rst    <= rst_hold_q | wd_expire;
    end
  end

endmodule

// File: tb/tb_aec_arbiter.sv
// Directed self-checking bench for aec_arbiter (table of jobs plus corner sequences).
module tb_aec_arbiter;
  import aec_pkg::*;

  localparam int NREQ    = 4;
  localparam int MAXLEN  = 16;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [7*NREQ-1:0] req_char = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [6:0]        rsp_result;
  logic              rsp_err;
  logic [6:0]        eng_ascii;
  logic              eng_ready;
  logic              eng_rst;
  logic              eng_valid = 1'b0;
  logic [6:0]        eng_result = '0;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int         id;
    string      expr;
    logic [6:0] res;
    bit         err;
  } job_t;

  job_t jobs[5];

  aec_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_char   (req_char),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .eng_ascii  (eng_ascii),
    .eng_ready  (eng_ready),
    .eng_rst    (eng_rst),
    .eng_valid  (eng_valid),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_eng_ascii"}, eng_ascii, 0);
    chk({tag, "_eng_ready"}, eng_ready, 0);
    chk({tag, "_eng_rst"}, eng_rst, 1);
  endtask

  // mode 0: engine answers; 1: engine silent (return in WAIT_RES); 2: reset on burst cycle 2
  task automatic send_job(input int id, input string expr, input logic [6:0] res,
                          input bit exp_err, input int mode, input bit chk_lat);
    logic [NREQ-1:0] oh;
    int  cnt;
    byte b;
    oh = NREQ'(1) << id;
    for (int i = 0; i < expr.len(); i++) begin
      b = expr[i];
      req_char[7*id +: 7] = b[6:0];
      req_valid[id] = 1'b1;
      cnt = 0;
      while (!req_ready[id] && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (!req_ready[id]) begin
        chk("ready_wait", req_ready[id], 1);
        req_valid[id] = 1'b0;
        return;
      end
      if (i == 0 && chk_lat) chk("grant_latency", cnt, 1);
      chk("ready_onehot", req_ready, oh);
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    if (exp_err) begin
      chk("ovf_no_burst", eng_ready, 0);
      chk("ovf_rsp_valid", rsp_valid, oh);
      chk("ovf_rsp_err", rsp_err, 1);
      chk("ovf_rsp_result", rsp_result, 0);
      @(negedge clk);
      chk("ovf_rsp_one_cycle", rsp_valid, 0);
      chk("ovf_still_no_burst", eng_ready, 0);
      return;
    end
    for (int k = 0; k < expr.len(); k++) begin
      b = expr[k];
      chk("burst_eng_ready", eng_ready, 1);
      chk("burst_eng_ascii", eng_ascii, b[6:0]);
      if (mode == 2 && k == 1) begin
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("wait_eng_ready_low", eng_ready, 0);
    if (mode == 1) return;
    repeat (2) @(negedge clk);
    chk("wait_no_rsp", rsp_valid, 0);
    eng_valid  = 1'b1;
    eng_result = res;
    @(negedge clk);
    eng_valid  = 1'b0;
    eng_result = '0;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_result", rsp_result, res);
    chk("rsp_err", rsp_err, 0);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    logic [NREQ-1:0] seen;
    int n;

    jobs[0] = '{0, "3+4=", 7'd7, 1'b0};
    jobs[1] = '{3, "1234567890123456=", 7'd0, 1'b1};
    jobs[2] = '{3, "123456789012345=", 7'd5, 1'b0};
    jobs[3] = '{2, "(1+2)*3-4=", 7'd9, 1'b0};
    jobs[4] = '{1, "=", 7'h55, 1'b0};

    // reset values and engine-reset stretch
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("eng_rst_stretch", eng_rst, 1);
    @(negedge clk);
    chk("eng_rst_released", eng_rst, 0);

    // engine strobe while idle must not produce a response
    eng_valid  = 1'b1;
    eng_result = 7'd5;
    @(negedge clk);
    eng_valid  = 1'b0;
    eng_result = '0;
    chk("idle_strobe_ignored", rsp_valid, 0);
    @(negedge clk);
    chk("idle_strobe_ignored2", rsp_valid, 0);

    // round-robin: req1 and req2 together with rr_ptr=0, req1 re-asserted during req2
    req_char[14 +: 7] = 7'h39;
    req_valid[2] = 1'b1;
    send_job(1, "1=", 7'h01, 1'b0, 0, 1'b1);
    fork
      send_job(2, "9=", 7'h02, 1'b0, 0, 1'b0);
      begin
        repeat (2) @(negedge clk);
        req_char[7 +: 7] = 7'h35;
        req_valid[1] = 1'b1;
      end
    join
    send_job(1, "5=", 7'h03, 1'b0, 0, 1'b0);

    // table of single-requester jobs
    for (int t = 0; t < 5; t++) begin
      send_job(jobs[t].id, jobs[t].expr, jobs[t].res, jobs[t].err, 0, 1'b1);
    end

    // silent engine
    send_job(0, "8*2=", 7'd0, 1'b0, 1, 1'b1);
`ifdef AEC_ARB_WDOG_EN
    n = 0;
    while (rsp_valid == '0 && n < TIMEOUT + 10) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_latency", n, TIMEOUT);
    chk("wdog_rsp_valid", rsp_valid, 1);
    chk("wdog_rsp_err", rsp_err, 1);
    chk("wdog_rsp_result", rsp_result, 0);
    chk("wdog_eng_rst", eng_rst, 1);
    @(negedge clk);
    chk("wdog_eng_rst_pulse", eng_rst, 0);
    chk("wdog_rsp_one_cycle", rsp_valid, 0);
`else
    seen = '0;
    n = 0;
    repeat (3 * TIMEOUT) begin
      @(negedge clk);
      seen = seen | rsp_valid | {NREQ{eng_rst}};
      n++;
    end
    chk("nowdog_holds", seen, 0);
    chk("nowdog_no_burst", eng_ready, 0);
    eng_valid  = 1'b1;
    eng_result = 7'd3;
    @(negedge clk);
    eng_valid  = 1'b0;
    eng_result = '0;
    chk("nowdog_rsp_valid", rsp_valid, 1);
    chk("nowdog_rsp_result", rsp_result, 3);
    chk("nowdog_rsp_err", rsp_err, 0);
    @(negedge clk);
`endif

    // reset on burst cycle 2, then re-grant cleanly
    send_job(0, "3+4=", 7'd7, 1'b0, 2, 1'b1);
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    send_job(0, "3+4=", 7'd7, 1'b0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/aec_arbiter.md
# aec_arbiter

Round-robin front-end that shares one arithmetic-expression-calculator engine among NREQ requesters. Each granted requester's ASCII expression is buffered in full through its terminating '='. The buffer is then burst into the engine at one character per cycle, because the engine samples a character on every cycle with no back-pressure. The engine's result is returned to the owning requester. The block sits between the host-side expression sources and the calculator engine, and owns the engine's reset.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- MAXLEN, 16: buffer depth in characters, including '='.
- TIMEOUT, 255: engine watchdog limit in cycles, 8-bit.

Ports:
- clk  in  1  clock.
- rst  in  1  active-low synchronous reset (low = reset).
- req_valid  in  NREQ  requester i presents a character.
- req_char  in  7*NREQ  ASCII character; requester i uses bits [7i+6:7i].
- req_ready  out  NREQ  a character is accepted when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NREQ  one-cycle pulse to requester i: response is available.
- rsp_result  out  7  result; valid only while some rsp_valid bit is high.
- rsp_err  out  1  error flag; qualified by rsp_valid.
- eng_ascii  out  7  character to the engine.
- eng_ready  out  1  high on every burst cycle.
- eng_rst  out  1  active-high engine reset.
- eng_valid  in  1  engine result strobe.
- eng_result  in  7  engine result.

## Operation
- State machine: IDLE, LOAD, BURST, WAIT_RES, RESP.
- IDLE
  - If any req_valid is high, grant the first set bit at or after rr_ptr, scanning upward with wrap.
  - Latch the grant index, set rr_ptr = grant+1 (mod NREQ), clear wr_idx and the overflow flag, go to LOAD.
- LOAD
  - req_ready[grant]=1; all other req_ready bits are 0.
  - Each accepted character is written to buf[wr_idx] and wr_idx increments, while wr_idx<MAXLEN.
  - Once wr_idx==MAXLEN, further characters are accepted and discarded, and the overflow flag is set.
  - On acceptance of '=' (0x3D): if overflow is set go to RESP with an error; otherwise go to BURST with len = wr_idx+1.
- BURST
  - eng_ascii = buf[rd_idx], eng_ready=1, rd_idx increments every cycle; there are no gaps.
  - After len cycles go to WAIT_RES.
- WAIT_RES
  - On eng_valid, latch eng_result and go to RESP with no error.
- RESP
  - rsp_valid[grant]=1 for exactly one cycle, with rsp_result and rsp_err driven; then go to IDLE.
- The engine needs one idle cycle after its valid strobe before it accepts new data. The RESP→IDLE→LOAD path guarantees at least 3 cycles, so no extra gap logic is needed.
- eng_rst:
  - Asserted while rst is low and for exactly 1 cycle after rst goes high.
  - Asserted for 1 cycle on a watchdog expiry.
- Characters are not checked for syntax; only '=' is interpreted.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, eng_ascii=0, eng_ready=0, eng_rst=1, rr_ptr=0, state=IDLE.
- Reset while in any state aborts the current job with no response; a partial expression is dropped.
- Grant latency: req_valid high in IDLE → req_ready high on the next cycle.
- The first burst cycle follows the cycle in which '=' was accepted.
- Response latency: rsp_valid rises 1 cycle after eng_valid is sampled.
- req_valid dropping during LOAD is legal; the block waits in LOAD indefinitely. The watchdog is not active in LOAD.
- Simultaneous requests are resolved by round-robin only; a request is never preempted mid-expression.
- eng_valid outside WAIT_RES is ignored.
- Overflow boundary: exactly MAXLEN characters including '=' is legal; MAXLEN+1 produces an error.

## Configuration
- AEC_ARB_WDOG_EN defined:
  - An 8-bit counter runs in WAIT_RES.
  - When it reaches TIMEOUT without eng_valid: pulse eng_rst for 1 cycle and go to RESP with rsp_err=1 and rsp_result=0.
- AEC_ARB_WDOG_EN undefined:
  - No counter is built; WAIT_RES waits indefinitely; eng_rst is driven by reset only.

## Structure
- Package aec_pkg holds:
  - ASCII constants: ASC_EQ=0x3D, ASC_PLUS=0x2B, ASC_MINUS=0x2D, ASC_MUL=0x2A, ASC_LP=0x28, ASC_RP=0x29.
  - The state enumeration.
  - Default MAXLEN.
- Sub-module aec_rr_pick: combinational round-robin priority picker taking req and ptr, producing grant index and any.
- The character buffer is a local register array; no separate FIFO module is used.

## Test plan
- Single request: req0 sends "3+4=".
  - Burst shows eng_ascii 0x33,0x2B,0x34,0x3D on 4 consecutive cycles with eng_ready=1.
  - Engine model returns 7; rsp_valid[0] pulses with rsp_result=7 and rsp_err=0.
- Round-robin: req1 and req2 are asserted in the same cycle with rr_ptr=0.
  - Order of service is req1, then req2; a re-asserted req1 during req2's job is served after req2.
- Overflow: req3 sends 16 digits followed by '='.
  - No burst occurs, eng_ready stays 0, rsp_valid[3] pulses with rsp_err=1.
  - A 15-digit expression plus '=' bursts normally.
- Watchdog (with AEC_ARB_WDOG_EN): engine model never strobes valid.
  - After TIMEOUT cycles in WAIT_RES, eng_rst pulses 1 cycle and rsp_err=1.
  - Without the macro, the block remains in WAIT_RES.
- Reset mid-burst: rst is driven low on burst cycle 2.
  - All outputs return to reset values and eng_rst is high.
  - After release the same request is re-granted from IDLE with no stale rsp_valid.
